// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter merging NUM_REQ producer streams into one fifo_ebr write port as {tag, data}.
// Optional per-grant bursting is enabled with the FIFO_ARB_BURST_EN macro.
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4,
    localparam int unsigned TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            fifo_input_valid_o,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_data_in_o,
    input  logic                            fifo_ready_for_input_i,
    output logic [TAG_WIDTH-1:0]            grant_idx_o
);

    if (NUM_REQ < 2 || BURST_LEN < 1) begin : gen_param_check
        $error("fifo_write_arbiter: NUM_REQ must be >= 2 and BURST_LEN >= 1");
    end

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e                          state_q, state_d;
    logic [TAG_WIDTH-1:0]            last_grant_q;
    logic [TAG_WIDTH-1:0]            grant_idx_q;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] data_q;
    logic [TAG_WIDTH-1:0]            rr_sel, sel, cand;
    logic                            found, drain, can_accept, accept;
    logic [DATA_WIDTH-1:0]           payload;

    // Cyclic search starting just after the last granted requester.
    always_comb begin
        rr_sel = last_grant_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = TAG_WIDTH'((32'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found  = 1'b1;
                rr_sel = cand;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int unsigned CntWidth = $clog2(BURST_LEN + 1);

    logic [CntWidth-1:0] beat_cnt_q, beat_cnt_d;
    logic                sticky;

    // Reset value BURST_LEN means no grant is held, so the first pick is round-robin.
    always_comb begin
        sticky     = req_valid_i[last_grant_q] && (beat_cnt_q < CntWidth'(BURST_LEN));
        sel        = sticky ? last_grant_q : rr_sel;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = sticky ? beat_cnt_q + 1'b1 : CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_cnt_q <= CntWidth'(BURST_LEN);
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign sel = rr_sel;
`endif

    assign drain      = (state_q == StFull) & fifo_ready_for_input_i;
    assign can_accept = (state_q == StEmpty) | drain;
    assign accept     = can_accept & (|req_valid_i) & ~reset_i;
    assign payload    = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o = NUM_REQ'(1) << sel;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (drain && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StEmpty;
            data_q       <= '0;
            last_grant_q <= TAG_WIDTH'(NUM_REQ - 1);
            grant_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q       <= {sel, payload};
                last_grant_q <= sel;
                grant_idx_q  <= sel;
            end
        end
    end

    assign fifo_input_valid_o = (state_q == StFull);
    assign fifo_data_in_o     = data_q;
    assign grant_idx_o        = grant_idx_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a round-robin reference model queues expected beats,
// an independent monitor pops and compares every FIFO write.
module tb_fifo_write_arbiter;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int BL = 4;
    localparam int TW = 2;
`ifdef FIFO_ARB_BURST_EN
    localparam int WaitBound = BL * (NR - 1);
`else
    localparam int WaitBound = NR - 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_input_valid;
    logic [TW+DW-1:0]  fifo_data_in;
    logic              fifo_ready;
    logic [TW-1:0]     grant_idx;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .BURST_LEN (BL)
    ) dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .req_valid_i           (req_valid),
        .req_data_i            (req_data),
        .req_ready_o           (req_ready),
        .fifo_input_valid_o    (fifo_input_valid),
        .fifo_data_in_o        (fifo_data_in),
        .fifo_ready_for_input_i(fifo_ready),
        .grant_idx_o           (grant_idx)
    );

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;
    int model_writes = 0;
    logic [TW+DW-1:0] exp_q[$];
    logic [DW-1:0]    cur_data[NR];
    logic             model_full;
    int               model_last;
    int               model_cnt;
    int               wait_cnt[NR];
    int               dut_grants[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Round-robin choice from the rules: keep a live burst, else first valid after last grant.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last, input int cnt);
`ifdef FIFO_ARB_BURST_EN
        if (v[last] && cnt < BL) return last;
`endif
        if (cnt < 0) return -1;
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        model_full = 1'b0;
        model_last = NR - 1;
        model_cnt  = BL;
        exp_q.delete();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    task automatic cycle(input logic [NR-1:0] v, input logic rdy);
        int sel;
        int dsel;
        logic [NR-1:0] exp_rdy;
        @(negedge clk);
        req_valid  = v;
        fifo_ready = rdy;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = cur_data[i];
        #1;
        chk("valid_out", {31'd0, fifo_input_valid}, {31'd0, model_full});
        sel = ((!model_full || rdy) && (|v)) ? rr_pick(v, model_last, model_cnt) : -1;
        exp_rdy = (sel >= 0) ? (NR'(1) << sel) : '0;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        dsel = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) dsel = i;
        for (int i = 0; i < NR; i++) begin
            if (!v[i]) begin
                wait_cnt[i] = 0;
            end else if (dsel >= 0) begin
                if (i == dsel) begin
                    checks++;
                    if (wait_cnt[i] > WaitBound) begin
                        errors++;
                        $display("FAIL max_wait req=%0d actual=%0d required<=%0d", i, wait_cnt[i],
                                 WaitBound);
                    end
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                end
            end
        end
        if (dsel >= 0) dut_grants.push_back(dsel);
        if (model_full && rdy) model_writes++;
        if (sel >= 0) begin
            exp_q.push_back({TW'(sel), cur_data[sel]});
            model_cnt  = (sel == model_last && v[model_last] && model_cnt < BL) ? model_cnt + 1 : 1;
            model_last = sel;
            cur_data[sel] = DW'($urandom);
        end
        model_full = (sel >= 0) || (model_full && !rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        req_valid  = '1;
        fifo_ready = 1'b0;
        #1;
        chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_valid", {31'd0, fifo_input_valid}, 32'd0);
        chk("rst_data", {14'd0, fifo_data_in}, 32'd0);
        chk("rst_grant", {30'd0, grant_idx}, 32'd0);
        model_reset();
    endtask

    // Monitor: every FIFO write must match the oldest expected beat.
    initial begin
        logic [TW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && fifo_input_valid && fifo_ready) begin
                dut_writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fifo_write actual=%0h required=<no beat pending>", fifo_data_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_data", {14'd0, fifo_data_in}, {14'd0, e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[6];
        int w0;
        reset      = 1'b1;
        req_valid  = '0;
        fifo_ready = 1'b0;
        req_data   = '0;
        for (int i = 0; i < NR; i++) cur_data[i] = DW'($urandom);
        model_reset();
        do_reset();

        // All requesters valid, no stall.
        dut_grants.delete();
        repeat (6) cycle(4'b1111, 1'b1);
`ifdef FIFO_ARB_BURST_EN
        exp_order = '{0, 0, 0, 0, 1, 1};
`else
        exp_order = '{0, 1, 2, 3, 0, 1};
`endif
        for (int i = 0; i < 6; i++) chk($sformatf("order%0d", i), dut_grants[i], exp_order[i]);

        // Only requester 2 valid with a fixed payload.
        repeat (3) cycle(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cur_data[2] = 16'hA5A5;
            cycle(4'b0100, 1'b1);
            chk("only2_ready", {28'd0, req_ready}, 32'h4);
        end
        cycle(4'b0000, 1'b1);
        chk("only2_data", {14'd0, fifo_data_in}, {14'd0, 2'd2, 16'hA5A5});
        repeat (2) cycle(4'b0000, 1'b1);

        // Stall with a pending beat.
        cur_data[1] = 16'h1234;
        cycle(4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0);
            chk("stall_data", {14'd0, fifo_data_in}, {14'd0, 2'd1, 16'h1234});
            chk("stall_ready", {28'd0, req_ready}, 32'd0);
        end
        w0 = dut_writes;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("stall_one_write", dut_writes - w0, 32'd1);

        // Reset while a beat is pending.
        repeat (3) cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b0);
        do_reset();
        dut_grants.delete();
        cycle(4'b1111, 1'b1);
        chk("post_reset_first", dut_grants[0], 32'd0);
        repeat (3) cycle(4'b0000, 1'b1);

`ifdef FIFO_ARB_BURST_EN
        do_reset();
        dut_grants.delete();
        repeat (6) cycle(4'b1111, 1'b1);
        cycle(4'b1101, 1'b1);
        chk("burst_drop", dut_grants[6], 32'd2);
        repeat (3) cycle(4'b0000, 1'b1);
`endif

        // Random valid/stall traffic.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            cycle(NR'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(4'b0000, 1'b1);
        chk("write_count", dut_writes, model_writes);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
